load_store_unit: RTL and testbench

Memory-side initiator for the mini-cpu: accepts load/store requests from the execute stage and drives the `data_memory` port (64-bit words, combinational read, write on rising `clk`). Implements RV64 byte/half/word/double accesses: sign/zero extension for loads, read-modify-write for sub-doubleword stores. Raises a misaligned error without touching memory.

---
 rtl/lsu_pkg.sv | 38 +++
 rtl/data_memory.sv | 30 +++
 rtl/lsu_align.sv | 49 ++++
 rtl/load_store_unit.sv | 119 +++++++++++
 tb/tb_load_store_unit.sv | 274 +++++++++++++++++++++++++++
 5 files changed

// File: rtl/lsu_pkg.sv
// Shared types and constants for the load/store unit: funct3 encodings,
// FSM state type and the access-legality check used when a request is accepted.
package lsu_pkg;

    localparam int xlen_default = 64;

    localparam logic [2:0] F3_B  = 3'b000;
    localparam logic [2:0] F3_H  = 3'b001;
    localparam logic [2:0] F3_W  = 3'b010;
    localparam logic [2:0] F3_D  = 3'b011;
    localparam logic [2:0] F3_BU = 3'b100;
    localparam logic [2:0] F3_HU = 3'b101;
    localparam logic [2:0] F3_WU = 3'b110;

    typedef enum logic [1:0] {
        IDLE  = 2'd0,
        READ  = 2'd1,
        WRITE = 2'd2,
        RESP  = 2'd3
    } lsu_state_t;

    // Unsupported encodings are folded into the misaligned error so the
    // unit never strobes memory for them.
    function automatic logic is_bad_access(input logic store,
                                           input logic [2:0] funct3,
                                           input logic [2:0] addr_lo);
        logic bad;
        bad = (funct3 == 3'b111) || (store && funct3[2]);
        case (funct3[1:0])
            2'b01:   bad = bad | addr_lo[0];
            2'b10:   bad = bad | (|addr_lo[1:0]);
            2'b11:   bad = bad | (|addr_lo);
            default: bad = bad;
        endcase
        return bad;
    endfunction

endpackage

// File: rtl/data_memory.sv
// Doubleword memory: combinational read, write on rising clk, writes ignored
// while reset is asserted. Address bits above the decoded range wrap.
module data_memory #(
    parameter int xlen      = 64,
    parameter int addr_bits = 10
) (
    input  logic            clk,
    input  logic            rstn,
    input  logic [xlen-1:0] address,
    input  logic [xlen-1:0] write_data,
    input  logic            write_en,
    input  logic            read_en,
    output logic [xlen-1:0] read_data
);

    logic [xlen-1:0]      mem [0:(1<<addr_bits)-1];
    logic [addr_bits-1:0] index;
    logic                 unused_bits;

    assign index       = address[addr_bits+2:3];
    assign unused_bits = ^{address[xlen-1:addr_bits+3], address[2:0]};
    assign read_data   = read_en ? mem[index] : '0;

    always_ff @(posedge clk) begin
        if (rstn && write_en) begin
            mem[index] <= write_data;
        end
    end

endmodule

// File: rtl/lsu_align.sv
// Byte-lane steering: extracts and sign/zero-extends load data from a
// doubleword, and merges sub-doubleword store data into a doubleword.
module lsu_align
    import lsu_pkg::*;
#(
    parameter int xlen = xlen_default
) (
    input  logic [2:0]      funct3,
    input  logic [2:0]      addr_lo,
    input  logic [xlen-1:0] word,
    input  logic [xlen-1:0] wdata,
    output logic [xlen-1:0] load_data,
    output logic [xlen-1:0] store_word
);

    logic [5:0]      bit_off;
    logic [xlen-1:0] shifted;
    logic [xlen-1:0] size_mask;

    assign bit_off = {addr_lo, 3'b000};
    assign shifted = word >> bit_off;

    always_comb begin
        load_data = shifted;
        case (funct3)
            F3_B:    load_data = {{(xlen-8){shifted[7]}}, shifted[7:0]};
            F3_H:    load_data = {{(xlen-16){shifted[15]}}, shifted[15:0]};
            F3_W:    load_data = {{(xlen-32){shifted[31]}}, shifted[31:0]};
            F3_BU:   load_data = {{(xlen-8){1'b0}}, shifted[7:0]};
            F3_HU:   load_data = {{(xlen-16){1'b0}}, shifted[15:0]};
            F3_WU:   load_data = {{(xlen-32){1'b0}}, shifted[31:0]};
            default: load_data = shifted;
        endcase
    end

    always_comb begin
        size_mask = '1;
        case (funct3[1:0])
            2'b00:   size_mask = {{(xlen-8){1'b0}}, 8'hFF};
            2'b01:   size_mask = {{(xlen-16){1'b0}}, 16'hFFFF};
            2'b10:   size_mask = {{(xlen-32){1'b0}}, 32'hFFFF_FFFF};
            default: size_mask = '1;
        endcase
    end

    // Lanes outside the access keep the previously read doubleword.
    assign store_word = (word & ~(size_mask << bit_off)) | ((wdata & size_mask) << bit_off);

endmodule

// File: rtl/load_store_unit.sv
// Load/store unit: accepts one request at a time, performs read or
// read-modify-write on a doubleword memory and returns one response.
module load_store_unit
    import lsu_pkg::*;
#(
    parameter int xlen      = xlen_default,
    parameter int addr_bits = 10
) (
    input  logic            clk,
    input  logic            rstn,
    input  logic            req_valid,
    output logic            req_ready,
    input  logic            req_store,
    input  logic [2:0]      req_funct3,
    input  logic [xlen-1:0] req_addr,
    input  logic [xlen-1:0] req_wdata,
    output logic            resp_valid,
    input  logic            resp_ready,
    output logic [xlen-1:0] resp_data,
    output logic            resp_misaligned,
    output logic [xlen-1:0] mem_address,
    output logic [xlen-1:0] mem_write_data,
    output logic            mem_write_en,
    output logic            mem_read_en,
    input  logic [xlen-1:0] mem_read_data
);

    localparam int unused_addr_bits = addr_bits;

    lsu_state_t      state, next_state;
    logic            accept;
    logic            bad_access;
    logic            store_q;
    logic [2:0]      funct3_q;
    logic [xlen-1:0] addr_q;
    logic [xlen-1:0] wdata_q;
    logic [xlen-1:0] word_q;
    logic [xlen-1:0] align_word;
    logic [xlen-1:0] load_data;
    logic [xlen-1:0] store_word;

    assign accept     = (state == IDLE) && req_valid;
    assign bad_access = is_bad_access(req_store, req_funct3, req_addr[2:0]);

    always_ff @(posedge clk or negedge rstn) begin
        if (!rstn) begin
            state <= IDLE;
        end else begin
            state <= next_state;
        end
    end

    always_comb begin
        next_state = state;
        case (state)
            IDLE: begin
                if (req_valid) begin
                    if (bad_access)
                        next_state = RESP;
                    else if (req_store && (req_funct3 == F3_D))
                        next_state = WRITE;
                    else
                        next_state = READ;
                end
            end
            READ:    next_state = store_q ? WRITE : RESP;
            WRITE:   next_state = RESP;
            RESP:    next_state = resp_ready ? IDLE : RESP;
            default: next_state = IDLE;
        endcase
    end

    // Request fields and the read-back word carry no reset; they are only
    // consumed in states reachable after an accept.
    always_ff @(posedge clk) begin
        if (accept) begin
            store_q  <= req_store;
            funct3_q <= req_funct3;
            addr_q   <= req_addr;
            wdata_q  <= req_wdata;
        end
        if (state == READ) begin
            word_q <= mem_read_data;
        end
    end

    always_ff @(posedge clk or negedge rstn) begin
        if (!rstn) begin
            resp_data       <= '0;
            resp_misaligned <= 1'b0;
        end else if (accept) begin
            resp_data       <= '0;
            resp_misaligned <= bad_access;
        end else if ((state == READ) && !store_q) begin
            resp_data <= load_data;
        end
    end

    // Extraction works on live memory data during READ; the merge works on
    // the word captured at the end of READ.
    assign align_word = (state == READ) ? mem_read_data : word_q;

    lsu_align #(.xlen(xlen)) u_align (
        .funct3     (funct3_q),
        .addr_lo    (addr_q[2:0]),
        .word       (align_word),
        .wdata      (wdata_q),
        .load_data  (load_data),
        .store_word (store_word)
    );

    assign req_ready      = (state == IDLE);
    assign resp_valid     = (state == RESP);
    assign mem_read_en    = (state == READ);
    assign mem_write_en   = (state == WRITE);
    assign mem_address    = ((state == READ) || (state == WRITE)) ? {addr_q[xlen-1:3], 3'b000} : '0;
    assign mem_write_data = (state == WRITE) ? store_word : '0;

endmodule

// File: tb/tb_load_store_unit.sv
// Scoreboard bench for load_store_unit driving a real data_memory.
module tb_load_store_unit;

    localparam int xlen      = 64;
    localparam int addr_bits = 10;

    logic            clk = 1'b0;
    logic            rstn = 1'b0;
    logic            req_valid = 1'b0;
    logic            req_ready;
    logic            req_store = 1'b0;
    logic [2:0]      req_funct3 = 3'b000;
    logic [xlen-1:0] req_addr = '0;
    logic [xlen-1:0] req_wdata = '0;
    logic            resp_valid;
    logic            resp_ready = 1'b1;
    logic [xlen-1:0] resp_data;
    logic            resp_misaligned;
    logic [xlen-1:0] mem_address;
    logic [xlen-1:0] mem_write_data;
    logic            mem_write_en;
    logic            mem_read_en;
    logic [xlen-1:0] mem_read_data;

    always #5 clk = ~clk;

    load_store_unit #(.xlen(xlen), .addr_bits(addr_bits)) dut (
        .clk             (clk),
        .rstn            (rstn),
        .req_valid       (req_valid),
        .req_ready       (req_ready),
        .req_store       (req_store),
        .req_funct3      (req_funct3),
        .req_addr        (req_addr),
        .req_wdata       (req_wdata),
        .resp_valid      (resp_valid),
        .resp_ready      (resp_ready),
        .resp_data       (resp_data),
        .resp_misaligned (resp_misaligned),
        .mem_address     (mem_address),
        .mem_write_data  (mem_write_data),
        .mem_write_en    (mem_write_en),
        .mem_read_en     (mem_read_en),
        .mem_read_data   (mem_read_data)
    );

    data_memory #(.xlen(xlen), .addr_bits(addr_bits)) u_mem (
        .clk        (clk),
        .rstn       (rstn),
        .address    (mem_address),
        .write_data (mem_write_data),
        .write_en   (mem_write_en),
        .read_en    (mem_read_en),
        .read_data  (mem_read_data)
    );

    typedef struct {
        string       name;
        logic [63:0] data;
        logic        mis;
        int          lat;
        int          reads;
        int          writes;
        int          acc;
    } exp_t;

    exp_t sb[$];
    exp_t mon_e;
    int   checks = 0;
    int   fails = 0;
    int   cyc = 0;
    int   rd_cnt = 0;
    int   wr_cnt = 0;
    int   first_cyc = -1;
    bit   overlap = 1'b0;

    always @(posedge clk) cyc <= cyc + 1;

    task automatic check64(input string name, input logic [63:0] act, input logic [63:0] exp);
        checks++;
        if (act !== exp) begin
            fails++;
            $display("FAIL %s: got 0x%h expected 0x%h", name, act, exp);
        end
    endtask

    task automatic check_int(input string name, input int act, input int exp);
        checks++;
        if (act != exp) begin
            fails++;
            $display("FAIL %s: got %0d expected %0d", name, act, exp);
        end
    endtask

    // Monitor: strobe accounting plus response comparison on each handshake.
    always @(negedge clk) begin
        if (rstn) begin
            if (mem_read_en) rd_cnt++;
            if (mem_write_en) wr_cnt++;
            if (mem_read_en && mem_write_en) overlap = 1'b1;
            if (resp_valid && first_cyc < 0) first_cyc = cyc;
            if (resp_valid && resp_ready) begin
                if (sb.size() == 0) begin
                    checks++;
                    fails++;
                    $display("FAIL unexpected_resp: got response with empty scoreboard");
                end else begin
                    mon_e = sb.pop_front();
                    check64({mon_e.name, ".data"}, resp_data, mon_e.data);
                    check64({mon_e.name, ".mis"}, {63'd0, resp_misaligned}, {63'd0, mon_e.mis});
                    check_int({mon_e.name, ".lat"}, first_cyc - mon_e.acc + 1, mon_e.lat);
                    check_int({mon_e.name, ".reads"}, rd_cnt, mon_e.reads);
                    check_int({mon_e.name, ".writes"}, wr_cnt, mon_e.writes);
                    check_int({mon_e.name, ".overlap"}, int'(overlap), 0);
                end
                rd_cnt = 0;
                wr_cnt = 0;
                overlap = 1'b0;
                first_cyc = -1;
            end
        end
    end

    task automatic issue(input string name, input bit store, input logic [2:0] f3,
                         input logic [63:0] addr, input logic [63:0] wdata,
                         input logic [63:0] exp_data, input bit mis,
                         input int lat, input int reads, input int writes);
        exp_t e;
        int   guard;
        guard = 0;
        @(negedge clk);
        while (!req_ready && guard < 50) begin
            @(negedge clk);
            guard++;
        end
        if (!req_ready) begin
            checks++;
            fails++;
            $display("FAIL %s.ready_timeout: req_ready stayed 0 expected 1", name);
            return;
        end
        req_valid  = 1'b1;
        req_store  = store;
        req_funct3 = f3;
        req_addr   = addr;
        req_wdata  = wdata;
        @(posedge clk);
        #1;
        e.name   = name;
        e.data   = exp_data;
        e.mis    = mis;
        e.lat    = lat;
        e.reads  = reads;
        e.writes = writes;
        e.acc    = cyc;
        sb.push_back(e);
        req_valid = 1'b0;
    endtask

    task automatic wait_done(input string name);
        int guard;
        guard = 0;
        while (sb.size() != 0 && guard < 50) begin
            @(negedge clk);
            guard++;
        end
        if (sb.size() != 0) begin
            checks++;
            fails++;
            $display("FAIL %s.resp_timeout: %0d responses outstanding expected 0", name, sb.size());
            sb.delete();
        end
    endtask

    task automatic txn(input string name, input bit store, input logic [2:0] f3,
                       input logic [63:0] addr, input logic [63:0] wdata,
                       input logic [63:0] exp_data, input bit mis,
                       input int lat, input int reads, input int writes);
        issue(name, store, f3, addr, wdata, exp_data, mis, lat, reads, writes);
        wait_done(name);
    endtask

    initial begin
        #200000;
        $display("FAIL global_timeout: simulation did not finish");
        $fatal(1, "timeout");
    end

    initial begin
        int guard;
        // Reset state
        repeat (3) @(negedge clk);
        check64("rst.req_ready", {63'd0, req_ready}, 64'd1);
        check64("rst.resp_valid", {63'd0, resp_valid}, 64'd0);
        check64("rst.strobes", {62'd0, mem_read_en, mem_write_en}, 64'd0);
        check64("rst.mem_address", mem_address, 64'd0);
        check64("rst.mem_write_data", mem_write_data, 64'd0);
        check64("rst.resp_data", resp_data, 64'd0);
        rstn = 1'b1;
        @(negedge clk);
        check64("post_rst.req_ready", {63'd0, req_ready}, 64'd1);
        check64("post_rst.strobes", {62'd0, mem_read_en, mem_write_en}, 64'd0);
        check64("post_rst.resp_valid", {63'd0, resp_valid}, 64'd0);

        //  name         st f3      addr   wdata                  expected               mis lat r w
        txn("sd_10",     1, 3'b011, 64'h10, 64'h8877665544332211, 64'h0,                 0, 2, 0, 1);
        txn("ld_10",     0, 3'b011, 64'h10, 64'h0,                64'h8877665544332211, 0, 2, 1, 0);
        txn("sb_13",     1, 3'b000, 64'h13, 64'hFFFFFFFFFFFFFFAB, 64'h0,                 0, 3, 1, 1);
        txn("ld_10b",    0, 3'b011, 64'h10, 64'h0,                64'h88776655AB332211, 0, 2, 1, 0);
        txn("lb_13",     0, 3'b000, 64'h13, 64'h0,                64'hFFFFFFFFFFFFFFAB, 0, 2, 1, 0);
        txn("lbu_13",    0, 3'b100, 64'h13, 64'h0,                64'h00000000000000AB, 0, 2, 1, 0);
        txn("lh_11",     0, 3'b001, 64'h11, 64'h0,                64'h0,                 1, 1, 0, 0);
        txn("sw_0a",     1, 3'b010, 64'h0A, 64'hDEADBEEFDEADBEEF, 64'h0,                 1, 1, 0, 0);
        txn("ld_0c",     0, 3'b011, 64'h0C, 64'h0,                64'h0,                 1, 1, 0, 0);
        txn("l111_10",   0, 3'b111, 64'h10, 64'h0,                64'h0,                 1, 1, 0, 0);
        txn("s100_10",   1, 3'b100, 64'h10, 64'hFFFFFFFFFFFFFFFF, 64'h0,                 1, 1, 0, 0);
        txn("ld_10c",    0, 3'b011, 64'h10, 64'h0,                64'h88776655AB332211, 0, 2, 1, 0);
        txn("lw_14",     0, 3'b010, 64'h14, 64'h0,                64'hFFFFFFFF88776655, 0, 2, 1, 0);
        txn("lwu_14",    0, 3'b110, 64'h14, 64'h0,                64'h0000000088776655, 0, 2, 1, 0);
        txn("sh_16",     1, 3'b001, 64'h16, 64'hABCDEF0000001234, 64'h0,                 0, 3, 1, 1);
        txn("ld_10d",    0, 3'b011, 64'h10, 64'h0,                64'h12346655AB332211, 0, 2, 1, 0);
        txn("lh_12",     0, 3'b001, 64'h12, 64'h0,                64'hFFFFFFFFFFFFAB33, 0, 2, 1, 0);
        txn("lhu_12",    0, 3'b101, 64'h12, 64'h0,                64'h000000000000AB33, 0, 2, 1, 0);
        txn("lw_10",     0, 3'b010, 64'h10, 64'h0,                64'hFFFFFFFFAB332211, 0, 2, 1, 0);

        // Back-pressure: response must hold while resp_ready is low
        resp_ready = 1'b0;
        issue("stall_ld", 0, 3'b011, 64'h10, 64'h0, 64'h12346655AB332211, 0, 2, 1, 0);
        guard = 0;
        while (!resp_valid && guard < 20) begin
            @(negedge clk);
            guard++;
        end
        for (int i = 0; i < 5; i++) begin
            check64("stall.resp_valid", {63'd0, resp_valid}, 64'd1);
            check64("stall.resp_data", resp_data, 64'h12346655AB332211);
            check64("stall.req_ready", {63'd0, req_ready}, 64'd0);
            @(negedge clk);
        end
        resp_ready = 1'b1;
        wait_done("stall_ld");

        // Reset while a doubleword write is pending
        @(negedge clk);
        req_valid  = 1'b1;
        req_store  = 1'b1;
        req_funct3 = 3'b011;
        req_addr   = 64'h10;
        req_wdata  = 64'hDEADBEEFCAFEF00D;
        @(posedge clk);
        #1;
        req_valid = 1'b0;
        check64("rstw.write_en_before", {63'd0, mem_write_en}, 64'd1);
        rstn = 1'b0;
        #1;
        check64("rstw.req_ready", {63'd0, req_ready}, 64'd1);
        check64("rstw.write_en", {63'd0, mem_write_en}, 64'd0);
        check64("rstw.resp_valid", {63'd0, resp_valid}, 64'd0);
        check64("rstw.mem_address", mem_address, 64'd0);
        @(posedge clk);
        @(negedge clk);
        rstn = 1'b1;
        rd_cnt = 0;
        wr_cnt = 0;
        overlap = 1'b0;
        first_cyc = -1;
        txn("ld_after_rst", 0, 3'b011, 64'h10, 64'h0, 64'h12346655AB332211, 0, 2, 1, 0);

        repeat (2) @(negedge clk);
        $display("End of test - %0d assertions evaluated, %0d failures", checks, fails);
        $finish;
    end

endmodule
